// File: rtl/ln4017_pkg.sv
// Shared constants and decode helpers for logic consuming the ln4017 decade counter.
package ln4017_pkg;

    localparam logic [9:0] ONEHOT_RESET = 10'b1;
    localparam logic [3:0] BCD_MAX      = 4'd9;

    typedef struct packed {
        logic       legal;
        logic [3:0] bcd;
    } onehot_dec_t;

    typedef struct packed {
        logic       carry;
        logic [3:0] bcd;
    } bcd_inc_t;

    // legal only reports "exactly one bit set"; carry-output consistency is checked by the caller.
    function automatic onehot_dec_t onehot_to_bcd(input logic [9:0] q);
        onehot_dec_t r;
        int unsigned n;
        r.bcd = 4'd0;
        n     = 0;
        for (int i = 0; i < 10; i++) begin
            if (q[i]) begin
                n     = n + 1;
                r.bcd = 4'(i);
            end
        end
        r.legal = (n == 1);
        return r;
    endfunction

    function automatic bcd_inc_t bcd_inc(input logic [3:0] v);
        bcd_inc_t r;
        if (v >= BCD_MAX) begin
            r.carry = 1'b1;
            r.bcd   = 4'd0;
        end else begin
            r.carry = 1'b0;
            r.bcd   = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ln4017_sync.sv
// Multi-flop synchroniser with a configurable reset value, so the chain can
// come out of reset holding a known-legal upstream state.
module ln4017_sync #(
    parameter int              W       = 1,
    parameter int              STAGES  = 2,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stg_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_q[i] <= RST_VAL;
            end
        end else begin
            stg_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/ln4017_bcd_tally.sv
// BCD tally downstream of an ln4017: units from the synchronised one-hot count,
// NDEC ripple-BCD decades advanced by each upstream 9->0 rollover.
module ln4017_bcd_tally
    import ln4017_pkg::*;
#(
    parameter int NDEC        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              cp0,
    input  logic              mr,
    input  logic              en,
    input  logic              clr,
    input  logic [9:0]        in_q,
    input  logic              in_q59_b,
    output logic [3:0]        units,
    output logic [4*NDEC-1:0] decades,
    output logic              carry_pulse,
    output logic              ovf,
    output logic              err
);

    logic [9:0] s_q;
    logic       s_c;

    ln4017_sync #(
        .W       (10),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (ONEHOT_RESET)
    ) u_sync_q (
        .clk_i (cp0),
        .rst_i (mr),
        .d_i   (in_q),
        .q_o   (s_q)
    );

    ln4017_sync #(
        .W       (1),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_c (
        .clk_i (cp0),
        .rst_i (mr),
        .d_i   (in_q59_b),
        .q_o   (s_c)
    );

    logic              s_c_d_q;
    logic [3:0]        units_q, units_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              ill_q;
    logic [4*NDEC-1:0] dec_q, dec_d;

    onehot_dec_t dec;
    logic        legal;
    logic        rollover;
    logic        count_en;

    assign dec      = onehot_to_bcd(s_q);
    assign legal    = dec.legal && (s_c == ~|s_q[9:5]);
    assign rollover = s_c & ~s_c_d_q;
    assign count_en = rollover & en & ~clr;

    // inc[g] is the increment arriving at nibble g; inc[NDEC] means all nibbles wrapped.
    logic [NDEC:0] inc;
    assign inc[0] = count_en;

    for (genvar g = 0; g < NDEC; g++) begin : g_dec
        bcd_inc_t nib;
        assign nib        = bcd_inc(dec_q[4*g +: 4]);
        assign inc[g+1]   = inc[g] & nib.carry;
        assign dec_d[4*g +: 4] = clr    ? 4'd0    :
                                 inc[g] ? nib.bcd : dec_q[4*g +: 4];
    end

    always_comb begin
        units_d = legal ? dec.bcd : units_q;
        carry_d = count_en;
        ovf_d   = clr ? 1'b0 : (ovf_q | inc[NDEC]);
        // A single illegal sample is tolerated as transition skew; two in a row are not.
        err_d   = clr ? 1'b0 : (err_q | (~legal & ill_q));
    end

    always_ff @(posedge cp0 or posedge mr) begin
        if (mr) begin
            s_c_d_q <= 1'b1;
            units_q <= 4'd0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            ill_q   <= 1'b0;
            dec_q   <= '0;
        end else begin
            s_c_d_q <= s_c;
            units_q <= units_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            ill_q   <= ~legal;
            dec_q   <= dec_d;
        end
    end

    assign units       = units_q;
    assign decades     = dec_q;
    assign carry_pulse = carry_q;
    assign ovf         = ovf_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ln4017_bcd_tally.sv
// Bench for ln4017_bcd_tally: directed scenarios plus random upstream traffic,
// every cycle compared against an integer-tally reference model.
module tb_ln4017_bcd_tally;

    localparam int NDEC = 3;
    localparam int SS   = 2;
    localparam int MODV = 1000;

    typedef struct packed {
        logic [9:0] q;
        logic       c;
    } smp_t;

    localparam smp_t RST_SMP = '{q: 10'b1, c: 1'b1};

    logic              cp0 = 1'b0;
    logic              mr = 1'b0, en = 1'b1, clr = 1'b0, in_q59_b = 1'b1;
    logic [9:0]        in_q = 10'b1;
    logic [3:0]        units;
    logic [4*NDEC-1:0] decades;
    logic              carry_pulse, ovf, err;

    ln4017_bcd_tally #(.NDEC(NDEC), .SYNC_STAGES(SS)) dut (
        .cp0         (cp0),
        .mr          (mr),
        .en          (en),
        .clr         (clr),
        .in_q        (in_q),
        .in_q59_b    (in_q59_b),
        .units       (units),
        .decades     (decades),
        .carry_pulse (carry_pulse),
        .ovf         (ovf),
        .err         (err)
    );

    always #5 cp0 = ~cp0;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: upstream samples delayed through a queue, decades as a plain integer.
    smp_t hq[$];
    smp_t m_pv, m_sm;
    int   m_units, m_tally;
    bit   m_ovf, m_err, m_pulse;

    function automatic bit smp_legal(input smp_t s);
        return ($countones(s.q) == 1) && (s.c == (s.q < 10'd32));
    endfunction

    function automatic logic [4*NDEC-1:0] bcd_of(input int v);
        logic [4*NDEC-1:0] r;
        r = '0;
        for (int i = 0; i < NDEC; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bad_nibbles(input logic [4*NDEC-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < NDEC; i++) begin
            if (d[4*i +: 4] > 4'd9) n++;
        end
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge cp0 or posedge mr);
            if (mr) begin
                hq.delete();
                for (int i = 0; i <= SS; i++) hq.push_back(RST_SMP);
                m_units = 0; m_tally = 0; m_ovf = 0; m_err = 0; m_pulse = 0;
            end else begin
                m_pv = hq[0];
                m_sm = hq[1];
                if (smp_legal(m_sm)) m_units = $clog2(m_sm.q);
                if (clr) begin
                    m_tally = 0; m_ovf = 0; m_err = 0; m_pulse = 0;
                end else begin
                    if (!smp_legal(m_sm) && !smp_legal(m_pv)) m_err = 1;
                    m_pulse = m_sm.c && !m_pv.c && en;
                    if (m_pulse) begin
                        m_tally++;
                        if (m_tally == MODV) begin
                            m_tally = 0;
                            m_ovf   = 1;
                        end
                    end
                end
                hq.push_back('{q: in_q, c: in_q59_b});
                void'(hq.pop_front());
            end
        end
    end

    task automatic compare();
        check_val("units",   units,       m_units);
        check_val("decades", decades,     bcd_of(m_tally));
        check_val("carry",   carry_pulse, m_pulse);
        check_val("ovf",     ovf,         m_ovf);
        check_val("err",     err,         m_err);
        check_val("nib_range", bad_nibbles(decades), 0);
    endtask

    task automatic tick();
        @(posedge cp0);
        #1;
        if (carry_pulse === 1'b1) pulses++;
        compare();
    endtask

    task automatic drain();
        repeat (SS + 2) tick();
    endtask

    task automatic set_state(input int s);
        in_q     = 10'(1 << s);
        in_q59_b = (s < 5);
    endtask

    task automatic quick_roll();
        set_state(9); tick();
        set_state(0); tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        int st;
        #2 mr = 1'b1;
        tick(); tick();
        check_val("rst_units",   units,       0);
        check_val("rst_decades", decades,     0);
        check_val("rst_carry",   carry_pulse, 0);
        check_val("rst_ovf",     ovf,         0);
        check_val("rst_err",     err,         0);
        mr = 1'b0;

        // walk 0..9 and confirm update latency
        for (int k = 0; k < 10; k++) begin
            set_state(k);
            repeat (SS) tick();
            check_val("lat_early", units, (k == 0) ? 0 : k - 1);
            tick();
            check_val("lat_units", units, k);
            tick();
        end
        check_val("walk_err", err, 0);
        check_val("walk_dec", decades, 0);

        // 25 full cycles
        pulse_clr();
        pulses = 0;
        for (int r = 0; r < 25; r++) begin
            for (int s = 0; s < 10; s++) begin
                set_state(s); tick();
            end
        end
        drain();
        check_val("cnt25_dec",    decades, 12'h025);
        check_val("cnt25_pulses", pulses,  25);
        check_val("cnt25_ovf",    ovf,     0);

        // overflow
        pulse_clr();
        pulses = 0;
        repeat (999) quick_roll();
        drain();
        check_val("pre_dec", decades, 12'h999);
        check_val("pre_ovf", ovf, 0);
        check_val("pre_pulses", pulses, 999);
        set_state(9); tick();
        set_state(0);
        repeat (SS + 1) tick();
        check_val("wrap_carry", carry_pulse, 1);
        check_val("wrap_dec",   decades,     12'h000);
        check_val("wrap_ovf",   ovf,         1);
        quick_roll();
        drain();
        check_val("post_dec", decades, 12'h001);
        check_val("post_ovf", ovf, 1);

        // illegal samples
        set_state(3); drain();
        in_q = 10'b0000000011; tick();
        set_state(3); drain(); tick();
        check_val("ill1_err",   err,   0);
        check_val("ill1_units", units, 3);
        in_q = 10'b0000000011; repeat (3) tick();
        set_state(3); drain();
        check_val("ill3_err",   err,   1);
        check_val("ill3_units", units, 3);
        pulse_clr();
        check_val("clr_err", err, 0);
        in_q = 10'b0000100000; in_q59_b = 1'b1; repeat (2) tick();
        set_state(3); drain();
        check_val("incons_err", err, 1);
        pulse_clr();

        // enable and clear interplay
        set_state(0); drain();
        repeat (3) quick_roll();
        drain();
        check_val("en_pre_dec", decades, 12'h003);
        en = 1'b0;
        pulses = 0;
        repeat (5) quick_roll();
        drain();
        check_val("en0_dec",    decades, 12'h003);
        check_val("en0_pulses", pulses,  0);
        en = 1'b1;
        in_q = 10'b0; repeat (3) tick();
        set_state(0); drain();
        check_val("pre_clr_err", err, 1);
        set_state(9); drain();
        set_state(0);
        repeat (SS) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check_val("clrroll_carry", carry_pulse, 0);
        check_val("clrroll_dec",   decades,     0);
        check_val("clrroll_ovf",   ovf,         0);
        check_val("clrroll_err",   err,         0);
        drain();

        // async reset mid-count
        repeat (47) quick_roll();
        drain();
        check_val("pre_mr_dec", decades, 12'h047);
        set_state(4); drain();
        #3 mr = 1'b1;
        #1;
        check_val("amr_units",   units,       0);
        check_val("amr_decades", decades,     0);
        check_val("amr_carry",   carry_pulse, 0);
        check_val("amr_ovf",     ovf,         0);
        check_val("amr_err",     err,         0);
        set_state(0);
        tick();
        mr = 1'b0;
        pulses = 0;
        repeat (SS + 2) tick();
        check_val("amr_no_pulse", pulses, 0);

        // random traffic
        st = 0;
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 29) == 0) begin
                in_q     = 10'($urandom);
                in_q59_b = 1'($urandom);
            end else begin
                if ($urandom_range(0, 2) != 0) st = (st + 1) % 10;
                set_state(st);
            end
            tick();
        end
        clr = 1'b0;
        en  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
